jtag_gpio_tap: RTL

- Synthesizable JTAG TAP responder. It is the device-side end of the JTAG scan sequences issued by the bench/host: clocked reset, IR scan, DR scan, IDCODE readout.
- Runs entirely in the system `clk` domain and oversamples `tck`/`tms`/`tdi`.
- Provides the IDCODE, BYPASS and GPIO data registers. The GPIO register drives the board LEDs and reads the button.
- Sits in `top` between the JTAG pins and `led0..2`/`button_`.

---
 rtl/jtag_gpio_tap.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/jtag_gpio_tap.sv
// JTAG TAP responder (IDCODE, BYPASS, GPIO) oversampling tck in the clk domain.
// Optional JTAG_GPIO_SAMPLE_PRELOAD_EN adds SAMPLE_PRELOAD on the GPIO chain.
module jtag_gpio_tap #(
    parameter int          IR_LENGTH    = 4,
    parameter logic [31:0] IDCODE_VALUE = 32'h149511c3,
    parameter int          GPIO_WIDTH   = 3,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tck,
    input  logic                  tms,
    input  logic                  tdi,
    output logic                  tdo,
    output logic                  tdo_oe,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out
);

    localparam logic [IR_LENGTH-1:0] IR_IDCODE  = IR_LENGTH'(4'b0010);
    localparam logic [IR_LENGTH-1:0] IR_GPIO    = IR_LENGTH'(4'b1010);
    localparam logic [IR_LENGTH-1:0] IR_CAPTURE = IR_LENGTH'(4'b0101);
`ifdef JTAG_GPIO_SAMPLE_PRELOAD_EN
    localparam logic [IR_LENGTH-1:0] IR_SAMPLE  = IR_LENGTH'(4'b0001);
`endif

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] tck_sync, tms_sync, tdi_sync;
    logic                   tck_prev;
    logic                   tck_s, tms_s, tdi_s;
    logic                   tck_rise, tck_fall;

    logic [IR_LENGTH-1:0]  ir, ir_sr, ir_eff;
    logic [31:0]           id_sr;
    logic [GPIO_WIDTH-1:0] gpio_sr;
    logic                  byp_sr;
    logic                  sel_id, sel_gpio, sel_upd;
    logic                  dr_lsb;

    assign tck_s    = tck_sync[SYNC_STAGES-1];
    assign tms_s    = tms_sync[SYNC_STAGES-1];
    assign tdi_s    = tdi_sync[SYNC_STAGES-1];
    assign tck_rise = tck_s & ~tck_prev;
    assign tck_fall = ~tck_s & tck_prev;

    // TLR overrides the held instruction in the same cycle it is entered
    assign ir_eff  = (state == TLR) ? IR_IDCODE : ir;
    assign sel_id  = (ir_eff == IR_IDCODE);
    assign sel_upd = (ir_eff == IR_GPIO);
`ifdef JTAG_GPIO_SAMPLE_PRELOAD_EN
    assign sel_gpio = sel_upd || (ir_eff == IR_SAMPLE);
`else
    assign sel_gpio = sel_upd;
`endif
    assign dr_lsb = sel_id ? id_sr[0] : (sel_gpio ? gpio_sr[0] : byp_sr);

    always_comb begin
        state_next = state;
        if (tck_rise) begin
            case (state)
                TLR:      state_next = tms_s ? TLR      : RTI;
                RTI:      state_next = tms_s ? SEL_DR   : RTI;
                SEL_DR:   state_next = tms_s ? SEL_IR   : CAP_DR;
                CAP_DR:   state_next = tms_s ? EX1_DR   : SH_DR;
                SH_DR:    state_next = tms_s ? EX1_DR   : SH_DR;
                EX1_DR:   state_next = tms_s ? UPD_DR   : PAUSE_DR;
                PAUSE_DR: state_next = tms_s ? EX2_DR   : PAUSE_DR;
                EX2_DR:   state_next = tms_s ? UPD_DR   : SH_DR;
                UPD_DR:   state_next = tms_s ? SEL_DR   : RTI;
                SEL_IR:   state_next = tms_s ? TLR      : CAP_IR;
                CAP_IR:   state_next = tms_s ? EX1_IR   : SH_IR;
                SH_IR:    state_next = tms_s ? EX1_IR   : SH_IR;
                EX1_IR:   state_next = tms_s ? UPD_IR   : PAUSE_IR;
                PAUSE_IR: state_next = tms_s ? EX2_IR   : PAUSE_IR;
                EX2_IR:   state_next = tms_s ? UPD_IR   : SH_IR;
                UPD_IR:   state_next = tms_s ? SEL_DR   : RTI;
                default:  state_next = TLR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= TLR;
        end else begin
            state    <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tck_sync <= '0;
            tms_sync <= '0;
            tdi_sync <= '0;
            tck_prev <= 1'b0;
            ir       <= IR_IDCODE;
            ir_sr    <= '0;
            id_sr    <= '0;
            gpio_sr  <= '0;
            byp_sr   <= 1'b0;
            tdo      <= 1'b0;
            tdo_oe   <= 1'b0;
            gpio_out <= '0;
        end else begin
            tck_sync <= {tck_sync[SYNC_STAGES-2:0], tck};
            tms_sync <= {tms_sync[SYNC_STAGES-2:0], tms};
            tdi_sync <= {tdi_sync[SYNC_STAGES-2:0], tdi};
            tck_prev <= tck_s;
            if (state == TLR) ir <= IR_IDCODE;
            if (tck_rise) begin
                case (state)
                    CAP_IR: ir_sr <= IR_CAPTURE;
                    SH_IR:  ir_sr <= {tdi_s, ir_sr[IR_LENGTH-1:1]};
                    CAP_DR: begin
                        if (sel_id)        id_sr   <= IDCODE_VALUE;
                        else if (sel_gpio) gpio_sr <= gpio_in;
                        else               byp_sr  <= 1'b0;
                    end
                    SH_DR: begin
                        if (sel_id)        id_sr   <= {tdi_s, id_sr[31:1]};
                        else if (sel_gpio) gpio_sr <= {tdi_s, gpio_sr[GPIO_WIDTH-1:1]};
                        else               byp_sr  <= tdi_s;
                    end
                    default: ;
                endcase
            end
            if (tck_fall) begin
                if (state == UPD_IR) ir <= ir_sr;
                if (state == UPD_DR && sel_upd) gpio_out <= gpio_sr;
                tdo    <= (state == SH_IR) ? ir_sr[0] :
                          (state == SH_DR) ? dr_lsb : 1'b0;
                tdo_oe <= (state == SH_IR) || (state == SH_DR);
            end
        end
    end

endmodule
